mem_load_sequencer: RTL and testbench

- Sequences the power-up load of the CNN and FC weight memories from the IO block: CNN weights, then the input image into the CNN memory, with FC weights loaded into the FC memory in parallel.
- Owns the single write port of each memory during load; hands the CNN memory address port to the compute datapath once loading completes.
- Replaces ad-hoc loading logic with two explicit FSMs, word counters and a source-valid stall handshake.

---
 rtl/load_pkg.sv | 30 +++
 rtl/load_counter.sv | 36 +++
 rtl/mem_load_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mem_load_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the weight/image memory load sequencer.
// Holds the FSM state types and the default word counts, image base
// address and address widths used by the chip top and the memories.
package load_pkg;

    typedef enum logic [2:0] {
        C_IDLE,
        C_WAIT,
        C_CNN,
        C_IMG,
        C_DONE
    } cnn_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_LOAD,
        F_DONE
    } fc_state_t;

    localparam int DEF_DW        = 16;
    localparam int DEF_CNN_WORDS = 50704;
    localparam int DEF_IMG_WORDS = 1024;
    localparam int DEF_IMG_BASE  = 50704;
    localparam int DEF_FC_WORDS  = 11218;
    localparam int DEF_CAW       = 16;
    localparam int DEF_FAW       = 14;
    localparam int IMG_IDX_W     = 11;

endpackage

// File: rtl/load_counter.sv
// Terminal-count source index counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one (ignored once the terminal index is reached)
//   idx        : current index
//   last       : idx equals COUNT-1
module load_counter #(
    parameter int W     = 16,
    parameter int COUNT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         last
);

    logic [W-1:0] idx_reg;

    assign last = (idx_reg == W'(COUNT - 1));
    assign idx  = idx_reg;

    // Holding at the terminal index keeps the counter from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
        end else if (clr) begin
            idx_reg <= '0;
        end else if (en && !last) begin
            idx_reg <= idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_load_sequencer.sv
// Power-up loader for the CNN and FC weight memories.
// The CNN side loads CNN weights then the input image (at IMG_BASE) into the
// CNN memory; the FC side loads FC weights into the FC memory in parallel.
// Writes are registered one cycle after the source index is presented, and a
// low src_valid stalls the load (no write, index held).
// Ports:
//   clk, rst_n, start, src_valid           : control inputs
//   load_cnn/load_img/load_fc              : load requests to the IO block
//   *_src_idx / *_src_data                 : source index out, source word in
//   cnn_mem_* / fc_mem_*                   : memory write ports
//   cmp_req, cmp_addr, cmp_gnt             : compute access to CNN memory
//   busy, load_done                        : status
module mem_load_sequencer
    import load_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int CNN_WORDS = DEF_CNN_WORDS,
    parameter int IMG_WORDS = DEF_IMG_WORDS,
    parameter int IMG_BASE  = DEF_IMG_BASE,
    parameter int FC_WORDS  = DEF_FC_WORDS,
    parameter int CAW       = DEF_CAW,
    parameter int FAW       = DEF_FAW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 src_valid,
    output logic                 load_cnn,
    output logic                 load_fc,
    output logic                 load_img,
    output logic [CAW-1:0]       cnn_src_idx,
    output logic [IMG_IDX_W-1:0] img_src_idx,
    output logic [FAW-1:0]       fc_src_idx,
    input  logic [DW-1:0]        cnn_src_data,
    input  logic [DW-1:0]        img_src_data,
    input  logic [DW-1:0]        fc_src_data,
    output logic [CAW-1:0]       cnn_mem_addr,
    output logic [DW-1:0]        cnn_mem_wdata,
    output logic                 cnn_mem_we,
    output logic [FAW-1:0]       fc_mem_addr,
    output logic [DW-1:0]        fc_mem_wdata,
    output logic                 fc_mem_we,
    input  logic                 cmp_req,
    input  logic [CAW-1:0]       cmp_addr,
    output logic                 cmp_gnt,
    output logic                 busy,
    output logic                 load_done
);

    cnn_state_t c_state_reg, c_state_next;
    fc_state_t  f_state_reg, f_state_next;

    logic c_busy, f_busy, start_ok;
    logic cnn_en, img_en, fc_en;
    logic cnn_last, img_last, fc_last;

    logic [CAW-1:0] cnn_addr_reg, cnn_addr_next;
    logic [DW-1:0]  cnn_data_reg, cnn_data_next;
    logic           cnn_we_reg, cnn_we_next;
    logic [FAW-1:0] fc_addr_reg, fc_addr_next;
    logic [DW-1:0]  fc_data_reg, fc_data_next;
    logic           fc_we_reg, fc_we_next;
    logic           load_done_reg;

    // A start is only honoured when neither side is mid-load.
    assign busy     = c_busy | f_busy;
    assign start_ok = start & ~busy;

    load_counter #(.W(CAW), .COUNT(CNN_WORDS)) u_cnn_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(cnn_en),
        .idx(cnn_src_idx), .last(cnn_last)
    );

    load_counter #(.W(IMG_IDX_W), .COUNT(IMG_WORDS)) u_img_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(img_en),
        .idx(img_src_idx), .last(img_last)
    );

    load_counter #(.W(FAW), .COUNT(FC_WORDS)) u_fc_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(fc_en),
        .idx(fc_src_idx), .last(fc_last)
    );

    // State registers and registered write ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state_reg   <= C_IDLE;
            f_state_reg   <= F_IDLE;
            cnn_addr_reg  <= '0;
            cnn_data_reg  <= '0;
            cnn_we_reg    <= 1'b0;
            fc_addr_reg   <= '0;
            fc_data_reg   <= '0;
            fc_we_reg     <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            c_state_reg   <= c_state_next;
            f_state_reg   <= f_state_next;
            cnn_addr_reg  <= cnn_addr_next;
            cnn_data_reg  <= cnn_data_next;
            cnn_we_reg    <= cnn_we_next;
            fc_addr_reg   <= fc_addr_next;
            fc_data_reg   <= fc_data_next;
            fc_we_reg     <= fc_we_next;
            // Taken from the registered DONE states so it rises only after the
            // final write has left the write port; compute can then never
            // steal the address of a pending write. An accepted restart drops
            // it on the very next cycle.
            load_done_reg <= (c_state_reg == C_DONE) && (f_state_reg == F_DONE) && !start_ok;
        end
    end

    // Next-state logic.
    always_comb begin
        c_state_next = c_state_reg;
        unique case (c_state_reg)
            C_IDLE, C_DONE: if (start_ok) c_state_next = C_WAIT;
            C_WAIT:         if (src_valid) c_state_next = C_CNN;
            C_CNN:          if (src_valid && cnn_last) c_state_next = C_IMG;
            C_IMG:          if (src_valid && img_last) c_state_next = C_DONE;
            default:        c_state_next = C_IDLE;
        endcase

        f_state_next = f_state_reg;
        unique case (f_state_reg)
            F_IDLE, F_DONE: if (start_ok) f_state_next = F_WAIT;
            F_WAIT:         if (src_valid) f_state_next = F_LOAD;
            F_LOAD:         if (src_valid && fc_last) f_state_next = F_DONE;
            default:        f_state_next = F_IDLE;
        endcase
    end

    // FSM outputs: load requests, busy flags and per-cycle write enables.
    always_comb begin
        load_cnn = 1'b0;
        load_img = 1'b0;
        load_fc  = 1'b0;
        c_busy   = 1'b0;
        f_busy   = 1'b0;
        cnn_en   = 1'b0;
        img_en   = 1'b0;
        fc_en    = 1'b0;
        unique case (c_state_reg)
            C_WAIT: begin
                load_cnn = 1'b1;
                load_img = 1'b1;
                c_busy   = 1'b1;
            end
            C_CNN: begin
                load_cnn = 1'b1;
                load_img = 1'b1;
                c_busy   = 1'b1;
                cnn_en   = src_valid;
            end
            C_IMG: begin
                load_img = 1'b1;
                c_busy   = 1'b1;
                img_en   = src_valid;
            end
            default: ;
        endcase
        unique case (f_state_reg)
            F_WAIT: begin
                load_fc = 1'b1;
                f_busy  = 1'b1;
            end
            F_LOAD: begin
                load_fc = 1'b1;
                f_busy  = 1'b1;
                fc_en   = src_valid;
            end
            default: ;
        endcase
    end

    // Write datapath: address/data hold between writes; only we pulses.
    always_comb begin
        cnn_addr_next = cnn_addr_reg;
        cnn_data_next = cnn_data_reg;
        cnn_we_next   = 1'b0;
        if (cnn_en) begin
            cnn_addr_next = cnn_src_idx;
            cnn_data_next = cnn_src_data;
            cnn_we_next   = 1'b1;
        end else if (img_en) begin
            cnn_addr_next = CAW'(IMG_BASE) + CAW'(img_src_idx);
            cnn_data_next = img_src_data;
            cnn_we_next   = 1'b1;
        end

        fc_addr_next = fc_addr_reg;
        fc_data_next = fc_data_reg;
        fc_we_next   = 1'b0;
        if (fc_en) begin
            fc_addr_next = fc_src_idx;
            fc_data_next = fc_src_data;
            fc_we_next   = 1'b1;
        end
    end

    // Compute arbitration: the compute datapath takes the CNN address port
    // only after the full load has completed.
    assign load_done     = load_done_reg;
    assign cmp_gnt       = load_done_reg & cmp_req;
    assign cnn_mem_addr  = cmp_gnt ? cmp_addr : cnn_addr_reg;
    assign cnn_mem_we    = cnn_we_reg & ~cmp_gnt;
    assign cnn_mem_wdata = cnn_data_reg;
    assign fc_mem_addr   = fc_addr_reg;
    assign fc_mem_wdata  = fc_data_reg;
    assign fc_mem_we     = fc_we_reg;

endmodule

// File: tb/tb_mem_load_sequencer.sv
module tb_mem_load_sequencer;

    typedef logic [31:0] wr_t;   // {addr, data} of one expected write

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;
    logic [15:0] salt = 16'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            if (fails <= 50)
                $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source arrays: word value is a fixed scramble of kind and index.
    function automatic logic [15:0] word_of(input int kind, input int idx, input logic [15:0] s);
        logic [31:0] v;
        v = 32'(idx) * 32'd40503 + 32'(kind) * 32'd7919 + 32'd17;
        return v[15:0] ^ s;
    endfunction

    // ---------------- small-parameter DUT ----------------
    logic        rst_n = 1'b0, start = 1'b0, src_valid = 1'b0, cmp_req = 1'b0;
    logic [15:0] cmp_addr = '0;
    logic        load_cnn, load_fc, load_img, cnn_mem_we, fc_mem_we, cmp_gnt, busy, load_done;
    logic [15:0] cnn_src_idx, cnn_mem_addr, cnn_src_data, img_src_data, fc_src_data;
    logic [15:0] cnn_mem_wdata, fc_mem_wdata;
    logic [10:0] img_src_idx;
    logic [13:0] fc_src_idx, fc_mem_addr;

    assign cnn_src_data = word_of(0, int'(cnn_src_idx), salt);
    assign img_src_data = word_of(1, int'(img_src_idx), salt);
    assign fc_src_data  = word_of(2, int'(fc_src_idx), salt);

    mem_load_sequencer #(.CNN_WORDS(8), .IMG_WORDS(4), .IMG_BASE(8), .FC_WORDS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_valid(src_valid),
        .load_cnn(load_cnn), .load_fc(load_fc), .load_img(load_img),
        .cnn_src_idx(cnn_src_idx), .img_src_idx(img_src_idx), .fc_src_idx(fc_src_idx),
        .cnn_src_data(cnn_src_data), .img_src_data(img_src_data), .fc_src_data(fc_src_data),
        .cnn_mem_addr(cnn_mem_addr), .cnn_mem_wdata(cnn_mem_wdata), .cnn_mem_we(cnn_mem_we),
        .fc_mem_addr(fc_mem_addr), .fc_mem_wdata(fc_mem_wdata), .fc_mem_we(fc_mem_we),
        .cmp_req(cmp_req), .cmp_addr(cmp_addr), .cmp_gnt(cmp_gnt),
        .busy(busy), .load_done(load_done)
    );

    // ---------------- default-parameter DUT ----------------
    logic        b_rst_n = 1'b0, b_start = 1'b0, b_src_valid = 1'b0, b_cmp_req = 1'b0;
    logic [15:0] b_cmp_addr = '0;
    logic        b_load_cnn, b_load_fc, b_load_img, b_cnn_mem_we, b_fc_mem_we, b_cmp_gnt, b_busy, b_load_done;
    logic [15:0] b_cnn_src_idx, b_cnn_mem_addr, b_cnn_src_data, b_img_src_data, b_fc_src_data;
    logic [15:0] b_cnn_mem_wdata, b_fc_mem_wdata;
    logic [10:0] b_img_src_idx;
    logic [13:0] b_fc_src_idx, b_fc_mem_addr;

    assign b_cnn_src_data = word_of(0, int'(b_cnn_src_idx), salt);
    assign b_img_src_data = word_of(1, int'(b_img_src_idx), salt);
    assign b_fc_src_data  = word_of(2, int'(b_fc_src_idx), salt);

    mem_load_sequencer dut_big (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .src_valid(b_src_valid),
        .load_cnn(b_load_cnn), .load_fc(b_load_fc), .load_img(b_load_img),
        .cnn_src_idx(b_cnn_src_idx), .img_src_idx(b_img_src_idx), .fc_src_idx(b_fc_src_idx),
        .cnn_src_data(b_cnn_src_data), .img_src_data(b_img_src_data), .fc_src_data(b_fc_src_data),
        .cnn_mem_addr(b_cnn_mem_addr), .cnn_mem_wdata(b_cnn_mem_wdata), .cnn_mem_we(b_cnn_mem_we),
        .fc_mem_addr(b_fc_mem_addr), .fc_mem_wdata(b_fc_mem_wdata), .fc_mem_we(b_fc_mem_we),
        .cmp_req(b_cmp_req), .cmp_addr(b_cmp_addr), .cmp_gnt(b_cmp_gnt),
        .busy(b_busy), .load_done(b_load_done)
    );

    // ---------------- reference model for the small DUT ----------------
    wr_t cnn_q[$];
    wr_t fc_q[$];
    int  cnn_wr_total = 0;
    int  fc_wr_total  = 0;

    // One full load: CNN words at 0..7, image words at 8..11, FC words at 0..4.
    task automatic arm_model();
        for (int i = 0; i < 8; i++) cnn_q.push_back({16'(i), word_of(0, i, salt)});
        for (int j = 0; j < 4; j++) cnn_q.push_back({16'(8 + j), word_of(1, j, salt)});
        for (int i = 0; i < 5; i++) fc_q.push_back({16'(i), word_of(2, i, salt)});
    endtask

    // Advance one clock and check whatever the ports show.
    task automatic tick_s();
        wr_t exp;
        @(posedge clk);
        #1;
        if (rst_n) begin
            check_eq("cmp_gnt_rule", cmp_gnt, load_done & cmp_req);
            if (cnn_mem_we) begin
                cnn_wr_total++;
                exp = (cnn_q.size() > 0) ? cnn_q.pop_front() : 32'hDEAD_DEAD;
                check_eq("cnn_write", {cnn_mem_addr, cnn_mem_wdata}, exp);
            end
            if (fc_mem_we) begin
                fc_wr_total++;
                exp = (fc_q.size() > 0) ? fc_q.pop_front() : 32'hDEAD_DEAD;
                check_eq("fc_write", {2'b00, fc_mem_addr, fc_mem_wdata}, exp);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_s();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int pct, output int n);
        n = 0;
        while (!load_done && n < 400) begin
            src_valid = ($urandom_range(0, 99) < pct);
            tick_s();
            n++;
        end
        check_eq("done_within_bound", load_done, 1'b1);
    endtask

    task automatic check_load_totals(input string tag, input int c0, input int f0);
        check_eq({tag, "_cnn_writes"}, cnn_wr_total - c0, 12);
        check_eq({tag, "_fc_writes"}, fc_wr_total - f0, 5);
        check_eq({tag, "_cnn_q_left"}, cnn_q.size(), 0);
        check_eq({tag, "_fc_q_left"}, fc_q.size(), 0);
    endtask

    initial begin
        int n, k, c0, f0;
        salt = 16'($urandom);
        fork
            // ---------- small DUT directed + random scenarios ----------
            begin
                repeat (3) @(posedge clk);
                #1;
                check_eq("rst_flags", {load_cnn, load_fc, load_img, busy, load_done, cnn_mem_we, fc_mem_we, cmp_gnt}, 0);
                check_eq("rst_cnn_addr", cnn_mem_addr, 0);
                check_eq("rst_idx", {cnn_src_idx, img_src_idx, fc_src_idx}, 0);
                rst_n = 1'b1;
                repeat (2) tick_s();
                check_eq("idle_no_load", {load_cnn, busy}, 0);

                // Continuous valid: fixed latency.
                c0 = cnn_wr_total; f0 = fc_wr_total;
                arm_model();
                src_valid = 1'b1;
                pulse_start();
                check_eq("t1_busy", busy, 1'b1);
                check_eq("t1_load_req", {load_cnn, load_img, load_fc}, 3'b111);
                run_until_done(100, n);
                check_eq("t1_latency", n, 14);
                check_load_totals("t1", c0, f0);
                check_eq("t1_idle_after", {busy, load_cnn, load_img, load_fc, cnn_mem_we, fc_mem_we}, 0);
                $display("t1 done: latency %0d, writes cnn %0d fc %0d", n, cnn_wr_total - c0, fc_wr_total - f0);

                // Stall of 3 cycles at CNN index 3 (restart from DONE).
                c0 = cnn_wr_total; f0 = fc_wr_total;
                arm_model();
                src_valid = 1'b1;
                pulse_start();
                check_eq("t2_done_drop", load_done, 1'b0);
                k = 0;
                while (cnn_src_idx != 16'd3 && k < 50) begin
                    tick_s();
                    k++;
                end
                src_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick_s();
                    check_eq("t2_stall_idx", cnn_src_idx, 16'd3);
                    check_eq("t2_stall_we", cnn_mem_we, 1'b0);
                end
                run_until_done(100, n);
                check_eq("t2_latency", k + 3 + n, 17);
                check_load_totals("t2", c0, f0);
                $display("t2 done: stall at idx 3, latency %0d", k + 3 + n);

                // Random valid, start while busy ignored, then restart after done.
                c0 = cnn_wr_total; f0 = fc_wr_total;
                arm_model();
                pulse_start();
                for (int s = 0; s < 6; s++) begin
                    src_valid = ($urandom_range(0, 99) < 70);
                    tick_s();
                end
                pulse_start();
                run_until_done(70, n);
                check_load_totals("t3", c0, f0);
                c0 = cnn_wr_total; f0 = fc_wr_total;
                arm_model();
                pulse_start();
                check_eq("t3_restart_done", load_done, 1'b0);
                check_eq("t3_restart_busy", busy, 1'b1);
                run_until_done(60, n);
                check_load_totals("t3r", c0, f0);
                $display("t3 done: random valid with ignored start and reload");

                // Asynchronous reset mid-load at CNN index 5.
                arm_model();
                src_valid = 1'b1;
                pulse_start();
                k = 0;
                while (cnn_src_idx != 16'd5 && k < 50) begin
                    tick_s();
                    k++;
                end
                check_eq("t4_reached_idx5", cnn_src_idx, 16'd5);
                rst_n = 1'b0;
                #1;
                check_eq("t4_rst_flags", {load_cnn, load_fc, load_img, busy, load_done, cnn_mem_we, fc_mem_we, cmp_gnt}, 0);
                check_eq("t4_rst_addr", {cnn_mem_addr, fc_mem_addr}, 0);
                check_eq("t4_rst_idx", {cnn_src_idx, img_src_idx, fc_src_idx}, 0);
                cnn_q.delete();
                fc_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (5) tick_s();
                check_eq("t4_idle_after_rst", {busy, load_cnn, load_fc, cnn_mem_we, fc_mem_we}, 0);
                check_eq("t4_idx_after_rst", cnn_src_idx, 0);
                $display("t4 done: reset at idx 5 aborted load");

                // Compute arbitration.
                c0 = cnn_wr_total; f0 = fc_wr_total;
                cmp_req = 1'b1;
                cmp_addr = 16'h0003;
                arm_model();
                pulse_start();
                run_until_done(80, n);
                check_load_totals("t5", c0, f0);
                check_eq("t5_gnt", cmp_gnt, 1'b1);
                check_eq("t5_addr", cnn_mem_addr, 16'h0003);
                check_eq("t5_we", cnn_mem_we, 1'b0);
                cmp_addr = 16'($urandom);
                #1;
                check_eq("t5_addr_follow", cnn_mem_addr, cmp_addr);
                cmp_req = 1'b0;
                #1;
                check_eq("t5_gnt_release", cmp_gnt, 1'b0);
                $display("t5 done: compute grant after load");
            end

            // ---------- default-parameter full load ----------
            begin
                int bc, bf, bn;
                wr_t exp;
                bc = 0; bf = 0; bn = 0;
                repeat (3) @(posedge clk);
                #1;
                b_rst_n = 1'b1;
                b_src_valid = 1'b1;
                b_start = 1'b1;
                @(posedge clk);
                #1;
                b_start = 1'b0;
                while (!b_load_done && bn < 60000) begin
                    @(posedge clk);
                    #1;
                    bn++;
                    if (b_cnn_mem_we) begin
                        if (bc < 50704)      exp = {16'(bc), word_of(0, bc, salt)};
                        else if (bc < 51728) exp = {16'(50704 + (bc - 50704)), word_of(1, bc - 50704, salt)};
                        else                 exp = 32'hDEAD_DEAD;
                        check_eq("big_cnn_write", {b_cnn_mem_addr, b_cnn_mem_wdata}, exp);
                        bc++;
                    end
                    if (b_fc_mem_we) begin
                        exp = (bf < 11218) ? {16'(bf), word_of(2, bf, salt)} : 32'hDEAD_DEAD;
                        check_eq("big_fc_write", {2'b00, b_fc_mem_addr, b_fc_mem_wdata}, exp);
                        bf++;
                    end
                end
                check_eq("big_done", b_load_done, 1'b1);
                check_eq("big_cnn_count", bc, 51728);
                check_eq("big_fc_count", bf, 11218);
                $display("big load done: %0d cnn-side writes, %0d fc writes, %0d cycles", bc, bf, bn);
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
